// File: rtl/pipeline_ctrl.sv
// Pipeline hazard / halt controller for a five-stage in-order pipeline.
// Generates PC and stage-register write enables, bubble inserts and the
// PC source select from the current hazards and a RUN/DRAIN/HALTED FSM.
// Also keeps saturating stall and flush performance counters.
module pipeline_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        de_mem_read,
    input  logic [4:0]  de_rd_reg,
    input  logic        em_take,
    input  logic        mem_busy,
    input  logic        halt_req,
    input  logic        resume,
    output logic        pc_wren,
    output logic        fd_wren,
    output logic        de_wren,
    output logic        em_wren,
    output logic        mw_wren,
    output logic        fd_clr_n,
    output logic        de_clr_n,
    output logic        em_clr_n,
    output logic        pc_sel,
    output logic        halted,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  drain_cnt_q, drain_cnt_d;
    logic [15:0] stall_cnt_q, flush_cnt_q;

    logic lu;
    logic active;
    logic ev_busy;
    logic ev_take;
    logic ev_lu;

    // Load in EX whose destination feeds the instruction in ID (r0 never hazards).
    assign lu = de_mem_read && (de_rd_reg != 5'd0) &&
                ((id_uses_rs && (de_rd_reg == id_rs)) ||
                 (id_uses_rt && (de_rd_reg == id_rt)));

    // Events are only honoured while the pipeline is moving; priority busy > take > lu.
    assign active  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign ev_busy = active && mem_busy;
    assign ev_take = active && !mem_busy && em_take;
    assign ev_lu   = active && !mem_busy && !em_take && lu;

    // State, drain counter and performance counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= 3'd0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            if ((ev_busy || ev_lu) && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (ev_take && (flush_cnt_q != 16'hFFFF))
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    // Next-state logic and combinational pipeline controls.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        pc_wren     = 1'b1;
        fd_wren     = 1'b1;
        de_wren     = 1'b1;
        em_wren     = 1'b1;
        mw_wren     = 1'b1;
        fd_clr_n    = 1'b1;
        de_clr_n    = 1'b1;
        em_clr_n    = 1'b1;
        pc_sel      = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (halt_req) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = 3'd0;
                end
            end
            ST_DRAIN: begin
                // Stop fetching: the PC holds and a bubble enters FD each cycle.
                pc_wren  = 1'b0;
                fd_clr_n = 1'b0;
                if (!mem_busy) begin
                    drain_cnt_d = drain_cnt_q + 3'd1;
                    if (drain_cnt_d == 3'd4)
                        state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                pc_wren = 1'b0;
                fd_wren = 1'b0;
                de_wren = 1'b0;
                em_wren = 1'b0;
                mw_wren = 1'b0;
                if (resume)
                    state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (ev_busy) begin
            // Full freeze so nothing in flight is lost.
            pc_wren  = 1'b0;
            fd_wren  = 1'b0;
            de_wren  = 1'b0;
            em_wren  = 1'b0;
            mw_wren  = 1'b0;
            fd_clr_n = 1'b1;
            de_clr_n = 1'b1;
            em_clr_n = 1'b1;
        end else if (ev_take) begin
            // Redirect fetch and squash the three younger instructions at once.
            pc_wren  = 1'b1;
            pc_sel   = 1'b1;
            fd_wren  = 1'b1;
            de_wren  = 1'b1;
            em_wren  = 1'b1;
            mw_wren  = 1'b1;
            fd_clr_n = 1'b0;
            de_clr_n = 1'b0;
            em_clr_n = 1'b0;
        end else if (ev_lu) begin
            // Hold PC and FD, push a single bubble into DE.
            pc_wren  = 1'b0;
            fd_wren  = 1'b0;
            de_wren  = 1'b1;
            em_wren  = 1'b1;
            mw_wren  = 1'b1;
            fd_clr_n = 1'b1;
            de_clr_n = 1'b0;
            em_clr_n = 1'b1;
        end

        // Reset dominates: everything disabled and every stage cleared.
        if (!reset_n) begin
            pc_wren  = 1'b0;
            fd_wren  = 1'b0;
            de_wren  = 1'b0;
            em_wren  = 1'b0;
            mw_wren  = 1'b0;
            fd_clr_n = 1'b0;
            de_clr_n = 1'b0;
            em_clr_n = 1'b0;
            pc_sel   = 1'b0;
        end
    end

    assign halted    = (state_q == ST_HALTED);
    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus random
// stimulus, every cycle compared against a behavioural reference model.
module tb_pipeline_ctrl;

    logic        clk;
    logic        reset_n;
    logic [4:0]  id_rs, id_rt;
    logic        id_uses_rs, id_uses_rt;
    logic        de_mem_read;
    logic [4:0]  de_rd_reg;
    logic        em_take, mem_busy, halt_req, resume;
    logic        pc_wren, fd_wren, de_wren, em_wren, mw_wren;
    logic        fd_clr_n, de_clr_n, em_clr_n;
    logic        pc_sel, halted;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;

    pipeline_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .de_mem_read(de_mem_read), .de_rd_reg(de_rd_reg),
        .em_take(em_take), .mem_busy(mem_busy),
        .halt_req(halt_req), .resume(resume),
        .pc_wren(pc_wren), .fd_wren(fd_wren), .de_wren(de_wren),
        .em_wren(em_wren), .mw_wren(mw_wren),
        .fd_clr_n(fd_clr_n), .de_clr_n(de_clr_n), .em_clr_n(em_clr_n),
        .pc_sel(pc_sel), .halted(halted), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit do_check = 1'b0;

    // Reference model: mode 0 RUN, 1 DRAIN, 2 HALTED.
    int m_mode = 0;
    int m_dcnt = 0;
    int m_sc   = 0;
    int m_fc   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_lu();
        return de_mem_read && (de_rd_reg != 0) &&
               ((id_uses_rs && de_rd_reg == id_rs) || (id_uses_rt && de_rd_reg == id_rt));
    endfunction

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        logic [11:0] e, m, o;
        bit lu_m, moving;
        @(negedge clk);
        lu_m   = model_lu();
        moving = (m_mode != 2);
        e = 12'h0;
        m = 12'hFFF;
        e[1:0] = m_mode[1:0];
        e[2]   = (m_mode == 2);
        if (!reset_n) begin
            e[11:3] = 9'b0;
            m[3]    = 1'b0;
        end else if (!moving || mem_busy) begin
            e[11:7] = 5'b00000; e[6:4] = 3'b111; e[3] = 1'b0;
        end else if (em_take) begin
            e[11] = 1'b1; e[7] = 1'b1; e[6:4] = 3'b000; e[3] = 1'b1;
            m[10:8] = 3'b000;
        end else if (lu_m) begin
            e[11] = 1'b0; e[10] = 1'b0; e[8] = 1'b1; e[7] = 1'b1; e[5] = 1'b0;
            m[9] = 1'b0; m[6] = 1'b0; m[4] = 1'b0; m[3] = 1'b0;
        end else if (m_mode == 0) begin
            e[11:7] = 5'b11111; e[6:4] = 3'b111; e[3] = 1'b0;
        end else begin
            e[11] = 1'b0; e[9:7] = 3'b111; e[6:4] = 3'b011;
            m[10] = 1'b0; m[3] = 1'b0;
        end
        o = {pc_wren, fd_wren, de_wren, em_wren, mw_wren,
             fd_clr_n, de_clr_n, em_clr_n, pc_sel, halted, state};
        if (do_check) begin
            check_val("ctrl", {20'd0, o & m}, {20'd0, e & m});
            check_val("stall_cnt", {16'd0, stall_cnt}, m_sc);
            check_val("flush_cnt", {16'd0, flush_cnt}, m_fc);
        end
        @(posedge clk);
        if (!reset_n) begin
            m_mode = 0; m_dcnt = 0; m_sc = 0; m_fc = 0;
        end else begin
            if (moving && (mem_busy || (lu_m && !em_take)) && m_sc < 65535) m_sc++;
            if (moving && !mem_busy && em_take && m_fc < 65535) m_fc++;
            if (m_mode == 0 && halt_req) begin
                m_mode = 1; m_dcnt = 0;
            end else if (m_mode == 1 && !mem_busy) begin
                m_dcnt++;
                if (m_dcnt == 4) m_mode = 2;
            end else if (m_mode == 2 && resume) begin
                m_mode = 0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        de_mem_read = 1'b0; de_rd_reg = 5'd0; em_take = 1'b0;
        mem_busy = 1'b0; halt_req = 1'b0; resume = 1'b0;
    endtask

    task automatic random_inputs();
        id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
        id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
        de_mem_read = 1'($urandom); de_rd_reg = 5'($urandom_range(0, 3));
        em_take = ($urandom_range(0, 5) == 0);
        mem_busy = ($urandom_range(0, 4) == 0);
        halt_req = ($urandom_range(0, 30) == 0);
        resume = ($urandom_range(0, 6) == 0);
    endtask

    // Reset for a few cycles with noisy inputs, then release with idle inputs.
    task automatic do_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            random_inputs();
            cycle();
        end
        reset_n = 1'b1;
        idle_inputs();
    endtask

    // Run drain cycles until the FSM leaves DRAIN; optionally stall twice inside.
    task automatic count_drain(input bit with_busy, output int k);
        k = 0;
        while (state == 2'd1 && k < 20) begin
            mem_busy = with_busy && (k == 1 || k == 2);
            cycle();
            k++;
        end
        mem_busy = 1'b0;
    endtask

    int k;

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        cycle();
        do_check = 1'b1;
        do_reset();
        check_val("reset_state", {30'd0, state}, 32'd0);
        check_val("reset_halted", {31'd0, halted}, 32'd0);
        $display("txn reset: state=%0d stall=%0d flush=%0d", state, stall_cnt, flush_cnt);

        // Load-use stall, then the same pattern against r0.
        de_mem_read = 1'b1; de_rd_reg = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
        cycle();
        idle_inputs(); cycle();
        check_val("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
        de_mem_read = 1'b1; de_rd_reg = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        cycle();
        idle_inputs(); cycle();
        check_val("lu_r0_stall_cnt", {16'd0, stall_cnt}, 32'd1);
        $display("txn load-use: stall=%0d", stall_cnt);

        // Branch flush, then branch with a simultaneous load-use.
        do_reset();
        em_take = 1'b1; cycle();
        idle_inputs(); cycle();
        check_val("br_flush_cnt", {16'd0, flush_cnt}, 32'd1);
        em_take = 1'b1; de_mem_read = 1'b1; de_rd_reg = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1;
        cycle();
        idle_inputs(); cycle();
        check_val("br_lu_flush_cnt", {16'd0, flush_cnt}, 32'd2);
        check_val("br_lu_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        $display("txn branch: flush=%0d stall=%0d", flush_cnt, stall_cnt);

        // Memory busy for three cycles while a branch waits.
        do_reset();
        em_take = 1'b1; mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        mem_busy = 1'b0; cycle();
        idle_inputs(); cycle();
        check_val("busy_stall_cnt", {16'd0, stall_cnt}, 32'd3);
        check_val("busy_flush_cnt", {16'd0, flush_cnt}, 32'd1);
        $display("txn mem_busy+branch: stall=%0d flush=%0d", stall_cnt, flush_cnt);

        // Halt, resume, and halt with busy cycles inside DRAIN.
        do_reset();
        halt_req = 1'b1; cycle(); halt_req = 1'b0;
        count_drain(1'b0, k);
        check_val("drain_len", k, 32'd4);
        check_val("halted", {31'd0, halted}, 32'd1);
        halt_req = 1'b1; cycle(); halt_req = 1'b0;
        check_val("halt_ignored", {30'd0, state}, 32'd2);
        resume = 1'b1; cycle(); resume = 1'b0;
        check_val("resume_state", {30'd0, state}, 32'd0);
        $display("txn halt: drain=%0d", k);
        halt_req = 1'b1; cycle(); halt_req = 1'b0;
        count_drain(1'b1, k);
        check_val("drain_busy_len", k, 32'd6);
        resume = 1'b1; cycle(); resume = 1'b0;
        $display("txn halt+busy: drain=%0d", k);

        // Reset in the middle of DRAIN, then a fresh drain.
        halt_req = 1'b1; cycle(); halt_req = 1'b0;
        cycle(); cycle();
        do_reset();
        check_val("mid_drain_rst_state", {30'd0, state}, 32'd0);
        check_val("mid_drain_rst_stall", {16'd0, stall_cnt}, 32'd0);
        halt_req = 1'b1; cycle(); halt_req = 1'b0;
        count_drain(1'b0, k);
        check_val("drain_after_rst", k, 32'd4);
        resume = 1'b1; cycle(); resume = 1'b0;
        $display("txn reset-mid-drain: drain=%0d", k);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            random_inputs();
            reset_n = ($urandom_range(0, 99) != 0);
            cycle();
        end
        reset_n = 1'b1;
        $display("txn random: stall=%0d flush=%0d", stall_cnt, flush_cnt);

        // Saturation of the stall counter.
        do_reset();
        do_check = 1'b0;
        mem_busy = 1'b1;
        for (int i = 0; i < 65534; i++) cycle();
        check_val("sat_preload", {16'd0, stall_cnt}, 32'hFFFE);
        for (int i = 0; i < 3; i++) cycle();
        do_check = 1'b1;
        check_val("sat_hold", {16'd0, stall_cnt}, 32'hFFFF);
        cycle();
        $display("txn saturation: stall=%0h", stall_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
